// File: rtl/spi_reg_ctrl_pkg.sv
// Shared constants, frame layout and FSM state type for the SPI register controller.
package spi_reg_ctrl_pkg;

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned DATA_W  = 8;

    localparam int unsigned MAX_ADDR_DEF = 4;
    localparam int unsigned CLK_DIV_DEF  = 10;

    // Frame field bit positions
    localparam int unsigned FRM_WR_BIT   = 15;
    localparam int unsigned FRM_ADDR_MSB = 14;
    localparam int unsigned FRM_ADDR_LSB = 8;
    localparam int unsigned FRM_DATA_MSB = 7;
    localparam int unsigned FRM_DATA_LSB = 0;

    // Register addresses
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'd0;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'd1;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'd2;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'd3;
    localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'd4;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } frame_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_APPLY  = 2'd2
    } state_e;

endpackage

// File: rtl/spi_reg_ctrl_pwm_gen.sv
// PWM generator: prescaler, 8-bit counter, shadow/active duty with wrap-time reload.
module pwm_gen
    import spi_reg_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shadow_we_i,
    input  logic [DATA_W-1:0] shadow_wdata_i,
    output logic [DATA_W-1:0] duty_active_o,
    output logic              pwm_c
);

    localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0] active_q, active_d;
    logic              step_c;
    logic              wrap_c;

    // Next-state: prescaler step, counter advance, duty reload on 255->0 wrap
    always_comb begin
        step_c   = (pre_q == PRE_MAX);
        wrap_c   = step_c && (cnt_q == 8'hFF);
        pre_d    = step_c ? '0 : pre_q + PRE_W'(1);
        cnt_d    = step_c ? cnt_q + 8'd1 : cnt_q;
        shadow_d = shadow_we_i ? shadow_wdata_i : shadow_q;
        // A write landing on the wrap edge misses it: the old shadow is committed
        active_d = wrap_c ? shadow_q : active_q;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign duty_active_o = active_q;
    // Full-scale duty is forced high so 255 gives a constant 1
    assign pwm_c = (active_q == 8'hFF) || (cnt_q < active_q);

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI frame decoder: input slot, decode FSM, register bank and output pin mapping.
module spi_reg_ctrl
    import spi_reg_ctrl_pkg::*;
#(
    parameter int unsigned MAX_ADDR = MAX_ADDR_DEF,
    parameter int unsigned CLK_DIV  = CLK_DIV_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_valid,
    input  logic [FRAME_W-1:0] frame_data,
    output logic [7:0]         uo_out,
    output logic [7:0]         uio_out,
    output logic [7:0]         duty_active,
    output logic               wr_ack,
    output logic               err,
    output logic               ovf
);

    state_e      state_q, state_d;
    frame_t      slot_q, slot_d;
    logic        slot_full_q, slot_full_d;
    frame_t      cur_q, cur_d;
    logic        rej_q, rej_d;
    logic [15:0] en_out_q, en_out_d;
    logic [15:0] en_pwm_q, en_pwm_d;
    logic        wr_ack_q, wr_ack_d;
    logic        err_q, err_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  uo_q, uo_d;
    logic [7:0]  uio_q, uio_d;
    logic        slot_take_c;
    logic        shadow_we_c;
    logic        pwm_c;

    pwm_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pwm (
        .clk            (clk),
        .rst_n          (rst_n),
        .shadow_we_i    (shadow_we_c),
        .shadow_wdata_i (cur_q.data),
        .duty_active_o  (duty_active),
        .pwm_c          (pwm_c)
    );

    // Next-state: FSM, slot capture/overflow, register writes and pin mapping
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        slot_full_d = slot_full_q;
        cur_d       = cur_q;
        rej_d       = rej_q;
        en_out_d    = en_out_q;
        en_pwm_d    = en_pwm_q;
        wr_ack_d    = 1'b0;
        err_d       = 1'b0;
        ovf_d       = 1'b0;
        slot_take_c = 1'b0;
        shadow_we_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (slot_full_q) begin
                    state_d     = ST_DECODE;
                    cur_d       = slot_q;
                    slot_take_c = 1'b1;
                end
            end
            ST_DECODE: begin
                rej_d   = !cur_q.wr || (32'(cur_q.addr) > MAX_ADDR);
                state_d = ST_APPLY;
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
                if (rej_q) begin
                    err_d = 1'b1;
                end else begin
                    wr_ack_d = 1'b1;
                    case (cur_q.addr)
                        ADDR_EN_OUT_LO: en_out_d[7:0]  = cur_q.data;
                        ADDR_EN_OUT_HI: en_out_d[15:8] = cur_q.data;
                        ADDR_EN_PWM_LO: en_pwm_d[7:0]  = cur_q.data;
                        ADDR_EN_PWM_HI: en_pwm_d[15:8] = cur_q.data;
                        ADDR_DUTY:      shadow_we_c    = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The slot frees on the same edge the FSM takes it, so a new frame can land there
        if (slot_take_c) begin
            slot_full_d = 1'b0;
        end
        if (frame_valid) begin
            if (slot_full_q && !slot_take_c) begin
                ovf_d = 1'b1;
            end else begin
                slot_d = '{wr:   frame_data[FRM_WR_BIT],
                           addr: frame_data[FRM_ADDR_MSB:FRM_ADDR_LSB],
                           data: frame_data[FRM_DATA_MSB:FRM_DATA_LSB]};
                slot_full_d = 1'b1;
            end
        end

        // Pin i: disabled -> 0, pwm-enabled -> pwm, otherwise -> 1
        uo_d  = en_out_d[7:0]  & (~en_pwm_d[7:0]  | {8{pwm_c}});
        uio_d = en_out_d[15:8] & (~en_pwm_d[15:8] | {8{pwm_c}});
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            slot_full_q <= 1'b0;
            cur_q       <= '0;
            rej_q       <= 1'b0;
            en_out_q    <= '0;
            en_pwm_q    <= '0;
            wr_ack_q    <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            uo_q        <= '0;
            uio_q       <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            slot_full_q <= slot_full_d;
            cur_q       <= cur_d;
            rej_q       <= rej_d;
            en_out_q    <= en_out_d;
            en_pwm_q    <= en_pwm_d;
            wr_ack_q    <= wr_ack_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            uo_q        <= uo_d;
            uio_q       <= uio_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = uio_q;
    assign wr_ack  = wr_ack_q;
    assign err     = err_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed self-checking bench for spi_reg_ctrl (MAX_ADDR=4, CLK_DIV=10).
module tb_spi_reg_ctrl;

    logic        clk;
    logic        rst_n;
    logic        frame_valid;
    logic [15:0] frame_data;
    logic [7:0]  uo_out;
    logic [7:0]  uio_out;
    logic [7:0]  duty_active;
    logic        wr_ack;
    logic        err;
    logic        ovf;

    int n_checks;
    int n_fail;
    int ack_cnt;
    int err_cnt;
    int ovf_cnt;
    int cyc;

    spi_reg_ctrl #(
        .MAX_ADDR (4),
        .CLK_DIV  (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .uo_out      (uo_out),
        .uio_out     (uio_out),
        .duty_active (duty_active),
        .wr_ack      (wr_ack),
        .err         (err),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and cycle counter, sampled at the rising edge before update
    initial begin
        ack_cnt = 0; err_cnt = 0; ovf_cnt = 0; cyc = 0;
    end
    always @(posedge clk) begin
        ack_cnt = ack_cnt + int'(wr_ack);
        err_cnt = err_cnt + int'(err);
        ovf_cnt = ovf_cnt + int'(ovf);
        cyc     = cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] f);
        @(negedge clk);
        frame_valid = 1'b1;
        frame_data  = f;
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    // Ack or err must appear exactly 3 cycles after the frame is sampled
    task automatic resp(input string tag, input bit exp_ack);
        int la;
        int le;
        la = -1;
        le = -1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (wr_ack && la < 0) la = k;
            if (err && le < 0) le = k;
        end
        check({tag, "_ack_lat"}, 32'(la), exp_ack ? 32'd3 : 32'hFFFF_FFFF);
        check({tag, "_err_lat"}, 32'(le), exp_ack ? 32'hFFFF_FFFF : 32'd3);
    endtask

    task automatic wait_duty(input string tag, input logic [7:0] val);
        for (int k = 0; k < 2700; k++) begin
            if (duty_active == val) break;
            @(negedge clk);
        end
        check(tag, 32'(duty_active), 32'(val));
    endtask

    // Count cycles over one full PWM period where uo_out equals val
    task automatic count_uo(input logic [7:0] val, output int n);
        n = 0;
        for (int k = 0; k < 2560; k++) begin
            @(negedge clk);
            if (uo_out == val) n = n + 1;
        end
    endtask

    initial begin
        int a0;
        int e0;
        int o0;
        int n;
        int w;

        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        frame_valid = 1'b0;
        frame_data  = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_uo", 32'(uo_out), 32'h0);
        check("rst_uio", 32'(uio_out), 32'h0);
        check("rst_duty", 32'(duty_active), 32'h0);
        check("rst_pulses", 32'({wr_ack, err, ovf}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_pulses", 32'({wr_ack, err, ovf}), 32'h0);

        // Enable pin 0 static high
        send(16'h8001);
        resp("w8001", 1'b1);
        check("uo_after_8001", 32'(uo_out), 32'h01);
        send(16'h8200);
        resp("w8200", 1'b1);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (uo_out == 8'h01) n = n + 1;
        end
        check("uo_steady_01", 32'(n), 32'd30);

        // Rejected frames: read flag and out-of-range address
        send(16'h0001);
        resp("r0001", 1'b0);
        send(16'h00FF);
        resp("r00FF", 1'b0);
        send(16'h8A55);
        resp("a8A55", 1'b0);
        check("rej_uo", 32'(uo_out), 32'h01);
        check("rej_uio", 32'(uio_out), 32'h00);
        check("rej_duty", 32'(duty_active), 32'h00);

        // Upper output register
        send(16'h8103);
        resp("w8103", 1'b1);
        check("uio_03", 32'(uio_out), 32'h03);

        // Three consecutive strobes: third is dropped
        a0 = ack_cnt; o0 = ovf_cnt;
        @(negedge clk);
        frame_valid = 1'b1; frame_data = 16'h8003;
        @(negedge clk);
        frame_data = 16'h810F;
        @(negedge clk);
        frame_data = 16'h8000;
        @(negedge clk);
        frame_valid = 1'b0;
        check("ovf_pulse", 32'(ovf), 32'h1);
        @(negedge clk);
        check("ovf_one_cycle", 32'(ovf), 32'h0);
        repeat (8) @(negedge clk);
        check("burst_acks", 32'(ack_cnt - a0), 32'd2);
        check("burst_ovfs", 32'(ovf_cnt - o0), 32'd1);
        check("burst_uo", 32'(uo_out), 32'h03);
        check("burst_uio", 32'(uio_out), 32'h0F);

        // Two frames two clocks apart: both applied
        a0 = ack_cnt; o0 = ovf_cnt;
        @(negedge clk);
        frame_valid = 1'b1; frame_data = 16'h8100;
        @(negedge clk);
        frame_valid = 1'b0;
        @(negedge clk);
        frame_valid = 1'b1; frame_data = 16'h8001;
        @(negedge clk);
        frame_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("gap2_acks", 32'(ack_cnt - a0), 32'd2);
        check("gap2_ovfs", 32'(ovf_cnt - o0), 32'd0);
        check("gap2_uo", 32'(uo_out), 32'h01);
        check("gap2_uio", 32'(uio_out), 32'h00);

        // 50% duty on all low pins
        send(16'h80FF);
        resp("w80FF", 1'b1);
        send(16'h82FF);
        resp("w82FF", 1'b1);
        send(16'h8480);
        resp("w8480", 1'b1);
        wait_duty("duty_80", 8'h80);
        count_uo(8'hFF, n);
        check("duty80_high", 32'(n), 32'd1280);
        e0 = err_cnt;
        count_uo(8'h00, n);
        check("duty80_low", 32'(n), 32'd1280);
        check("duty80_no_err", 32'(err_cnt - e0), 32'd0);

        // Shadow write landing on the wrap edge commits the old shadow
        send(16'h8440);
        resp("w8440", 1'b1);
        wait_duty("duty_40", 8'h40);
        w = cyc;
        while (cyc < w + 2556) @(negedge clk);
        frame_valid = 1'b1; frame_data = 16'h8420;
        @(negedge clk);
        frame_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("wrap_write_ack", 32'(wr_ack), 32'h1);
        check("wrap_old_shadow", 32'(duty_active), 32'h40);
        while (cyc < w + 5119) @(negedge clk);
        check("pre_wrap_duty", 32'(duty_active), 32'h40);
        @(negedge clk);
        check("next_wrap_duty", 32'(duty_active), 32'h20);

        // Duty extremes
        send(16'h8400);
        resp("w8400", 1'b1);
        wait_duty("duty_00", 8'h00);
        count_uo(8'h00, n);
        check("duty00_const0", 32'(n), 32'd2560);
        send(16'h84FF);
        resp("w84FF", 1'b1);
        wait_duty("duty_FF", 8'hFF);
        count_uo(8'hFF, n);
        check("dutyFF_const1", 32'(n), 32'd2560);

        // Reset while 0x8003 is in DECODE
        a0 = ack_cnt; e0 = err_cnt; o0 = ovf_cnt;
        send(16'h8003);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_uo", 32'(uo_out), 32'h0);
        check("arst_uio", 32'(uio_out), 32'h0);
        check("arst_duty", 32'(duty_active), 32'h0);
        check("arst_pulses", 32'({wr_ack, err, ovf}), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arel_pulses", 32'({wr_ack, err, ovf}), 32'h0);
        repeat (8) @(negedge clk);
        check("arst_no_ack", 32'(ack_cnt - a0), 32'd0);
        check("arst_no_err_ovf", 32'((err_cnt - e0) + (ovf_cnt - o0)), 32'd0);
        check("arst_uo_after", 32'(uo_out), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
